// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-compatible display-side responder with a 2x16 DDRAM mirror.
// Define LCD_RESPONDER_READ_EN to honour rw=1 transfers (busy/AC and DDRAM read-back).
module lcd_responder #(
  parameter int EXEC_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] db,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       incr,
  output logic       busy,
  output logic       cmd_valid,
  output logic [8:0] cmd_code,
  output logic       err,
  output logic [7:0] db_out,
  output logic       db_oe,
  output logic [1:0] dbg_state
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] EXEC_LOAD = CW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {ST_SWEEP = 2'd0, ST_IDLE = 2'd1, ST_EXEC = 2'd2} state_e;

  // Bus sample layout: {en, rs, rw, db}
  logic [10:0]   sync_q [SYNC_STAGES];
  logic [10:0]   prev_q;
  logic          fall_q;
  logic [9:0]    xfer_q;

  state_e        state_q;
  logic [4:0]    sweep_cnt_q;
  logic [CW-1:0] exec_cnt_q;
  logic [6:0]    ac_q;
  logic          display_on_q, cursor_on_q, blink_on_q, two_line_q, incr_q;
  logic          cmd_valid_q, err_q;
  logic [8:0]    cmd_code_q;
  logic [7:0]    rd_char_q;
  logic [7:0]    mem [32];

  logic          x_rs, x_rw;
  logic [7:0]    x_db;
  logic [4:0]    ac_idx;
  logic          mem_we;
  logic [4:0]    mem_waddr;
  logic [7:0]    mem_wdata;

  assign x_rs   = xfer_q[9];
  assign x_rw   = xfer_q[8];
  assign x_db   = xfer_q[7:0];
  assign ac_idx = {ac_q[6], ac_q[3:0]};

  // AC only ever holds 0x00-0x0F or 0x40-0x4F, so line wrap is a bit-6 flip.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) ac_step = (a[3:0] == 4'hF) ? {~a[6], 6'b0} : a + 7'd1;
    else    ac_step = (a[3:0] == 4'h0) ? {~a[6], 2'b00, 4'hF} : a - 7'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      fall_q <= 1'b0;
      xfer_q <= '0;
    end else begin
      sync_q[0] <= {en, rs, rw, db};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      fall_q <= prev_q[10] & ~sync_q[SYNC_STAGES-1][10];
      xfer_q <= prev_q[9:0];
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sweep_cnt_q;
    mem_wdata = 8'h20;
    if (state_q == ST_SWEEP) begin
      mem_we = 1'b1;
    end else if (fall_q && state_q == ST_IDLE && x_rs && !x_rw) begin
      mem_we    = 1'b1;
      mem_waddr = ac_idx;
      mem_wdata = x_db;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

`ifdef LCD_RESPONDER_READ_EN
  logic       rise_q;
  logic [9:0] rise_bus_q;
  logic [7:0] db_out_q;
  logic       db_oe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q     <= 1'b0;
      rise_bus_q <= '0;
    end else begin
      rise_q     <= ~prev_q[10] & sync_q[SYNC_STAGES-1][10];
      rise_bus_q <= sync_q[SYNC_STAGES-1][9:0];
    end
  end

  assign db_out = db_out_q;
  assign db_oe  = db_oe_q;
`else
  assign db_out = 8'h00;
  assign db_oe  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SWEEP;
      sweep_cnt_q  <= '0;
      exec_cnt_q   <= '0;
      ac_q         <= '0;
      display_on_q <= 1'b0;
      cursor_on_q  <= 1'b0;
      blink_on_q   <= 1'b0;
      two_line_q   <= 1'b0;
      incr_q       <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
      err_q        <= 1'b0;
      rd_char_q    <= '0;
`ifdef LCD_RESPONDER_READ_EN
      db_out_q     <= '0;
      db_oe_q      <= 1'b0;
`endif
    end else begin
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (state_q != ST_SWEEP) rd_char_q <= mem[rd_addr];

      case (state_q)
        ST_SWEEP: begin
          sweep_cnt_q <= sweep_cnt_q + 5'd1;
          if (sweep_cnt_q == 5'd31) begin
            state_q    <= ST_EXEC;
            exec_cnt_q <= EXEC_LOAD;
          end
        end
        ST_EXEC: begin
          if (exec_cnt_q == '0) state_q <= ST_IDLE;
          else                  exec_cnt_q <= exec_cnt_q - CW'(1);
        end
        default: ;
      endcase

`ifdef LCD_RESPONDER_READ_EN
      if (rise_q && rise_bus_q[8]) begin
        db_oe_q  <= 1'b1;
        db_out_q <= rise_bus_q[9] ? mem[ac_idx] : {busy, ac_q};
      end
      if (fall_q && x_rw) db_oe_q <= 1'b0;
`endif

      if (fall_q) begin
`ifdef LCD_RESPONDER_READ_EN
        if (x_rw && !x_rs) begin
          // Busy-flag polls never start an exec window, so polling cannot stretch busy.
          cmd_valid_q <= 1'b1;
          cmd_code_q  <= {x_rs, x_db};
        end else
`endif
        if (state_q != ST_IDLE || x_rw != 1'b0 && `ifdef LCD_RESPONDER_READ_EN 1'b0 `else 1'b1 `endif) begin
          err_q <= 1'b1;
        end else begin
          cmd_valid_q <= 1'b1;
          cmd_code_q  <= {x_rs, x_db};
          state_q     <= ST_EXEC;
          exec_cnt_q  <= EXEC_LOAD;
          if (x_rs) begin
            ac_q <= ac_step(ac_q, incr_q);
          end else if (x_rw) begin
            ac_q <= ac_q;
          end else if (x_db[7]) begin
            if (x_db[5:4] == 2'b00) begin
              ac_q <= x_db[6:0];
            end else begin
              err_q       <= 1'b1;
              cmd_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end else if (x_db[6]) begin
            ac_q <= ac_q;
          end else if (x_db[5]) begin
            two_line_q <= x_db[3];
            err_q      <= ~x_db[4];
          end else if (x_db[4]) begin
            if (!x_db[3]) ac_q <= ac_step(ac_q, x_db[2]);
          end else if (x_db[3]) begin
            display_on_q <= x_db[2];
            cursor_on_q  <= x_db[1];
            blink_on_q   <= x_db[0];
          end else if (x_db[2]) begin
            incr_q <= x_db[1];
          end else if (x_db[1]) begin
            ac_q <= '0;
          end else if (x_db[0]) begin
            ac_q        <= '0;
            incr_q      <= 1'b1;
            state_q     <= ST_SWEEP;
            sweep_cnt_q <= '0;
          end
        end
      end
    end
  end

  assign rd_char    = rd_char_q;
  assign ac         = ac_q;
  assign display_on = display_on_q;
  assign cursor_on  = cursor_on_q;
  assign blink_on   = blink_on_q;
  assign two_line   = two_line_q;
  assign incr       = incr_q;
  assign busy       = (state_q != ST_IDLE);
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: table-driven instruction/data vectors plus hand sequences for
// reset sweep, busy timing, dropped strobes, clear, reset-during-sweep and read-back.
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] db = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       display_on, cursor_on, blink_on, two_line, incr, busy;
  logic       cmd_valid, err, db_oe;
  logic [8:0] cmd_code;
  logic [7:0] db_out;
  logic [1:0] dbg_state;

  lcd_responder #(.EXEC_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .rs(rs), .rw(rw), .db(db), .rd_addr(rd_addr),
    .rd_char(rd_char), .ac(ac), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .two_line(two_line), .incr(incr), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .err(err), .db_out(db_out),
    .db_oe(db_oe), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_mem [32];

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic       v;
    logic       e;
    logic [6:0] ac;
    logic [4:0] fl;   // {display_on, cursor_on, blink_on, two_line, incr}
  } vec_t;

  localparam int NV = 36;
  vec_t tbl [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic strobe(input logic r_s, input logic r_w, input logic [7:0] d);
    rs = r_s; rw = r_w; db = d; en = 1'b1;
    repeat (6) step();
    en = 1'b0;
  endtask

  task automatic monitor(input int n, output logic v, output logic e, output logic [8:0] code);
    v = 1'b0; e = 1'b0; code = '0;
    for (int i = 0; i < n; i++) begin
      step();
      if (cmd_valid) begin v = 1'b1; code = cmd_code; end
      if (err) e = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic xfer(input logic r_s, input logic r_w, input logic [7:0] d,
                      output logic v, output logic e, output logic [8:0] code);
    strobe(r_s, r_w, d);
    monitor(12, v, e, code);
    wait_idle();
  endtask

  task automatic do_reset();
    int n = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_ac", 32'(ac), 32'h00);
    check("rst_flags", 32'({display_on, cursor_on, blink_on, two_line, incr}), 32'b00001);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_pulses", 32'({cmd_valid, err}), 32'd0);
    check("rst_rd_char", 32'(rd_char), 32'h00);
    check("rst_readback", 32'({db_oe, db_out}), 32'd0);
    while (busy && n < 200) begin step(); n++; end
    check("rst_busy_cycles", 32'(n), 32'd36);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
  endtask

  task automatic check_mirror(input string name);
    logic [7:0] exp;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      exp_q.push_back(exp_mem[i]);
      step();
      exp = exp_q.pop_front();
      check(name, {16'(i), 8'h00, rd_char}, {16'(i), 8'h00, exp});
    end
  endtask

  initial begin
    logic v, e;
    logic [8:0] code;
    logic [6:0] prev_ac;
    int n;

    // Vector table
    tbl[0]  = '{1'b0, 8'h38, 1'b1, 1'b0, 7'h00, 5'b00011};
    tbl[1]  = '{1'b0, 8'h0E, 1'b1, 1'b0, 7'h00, 5'b11011};
    tbl[2]  = '{1'b0, 8'h06, 1'b1, 1'b0, 7'h00, 5'b11011};
    tbl[3]  = '{1'b0, 8'h02, 1'b1, 1'b0, 7'h00, 5'b11011};
    tbl[4]  = '{1'b1, 8'h4C, 1'b1, 1'b0, 7'h01, 5'b11011};
    tbl[5]  = '{1'b1, 8'h4F, 1'b1, 1'b0, 7'h02, 5'b11011};
    tbl[6]  = '{1'b1, 8'h41, 1'b1, 1'b0, 7'h03, 5'b11011};
    tbl[7]  = '{1'b1, 8'h44, 1'b1, 1'b0, 7'h04, 5'b11011};
    tbl[8]  = '{1'b0, 8'hC0, 1'b1, 1'b0, 7'h40, 5'b11011};
    for (int i = 0; i < 10; i++)
      tbl[9+i] = '{1'b0, 8'h14, 1'b1, 1'b0, 7'(8'h41 + i), 5'b11011};
    tbl[19] = '{1'b1, 8'h2B, 1'b1, 1'b0, 7'h4B, 5'b11011};
    tbl[20] = '{1'b0, 8'h8F, 1'b1, 1'b0, 7'h0F, 5'b11011};
    tbl[21] = '{1'b1, 8'h58, 1'b1, 1'b0, 7'h40, 5'b11011};
    tbl[22] = '{1'b0, 8'h10, 1'b1, 1'b0, 7'h0F, 5'b11011};
    tbl[23] = '{1'b0, 8'h14, 1'b1, 1'b0, 7'h40, 5'b11011};
    tbl[24] = '{1'b0, 8'h04, 1'b1, 1'b0, 7'h40, 5'b11010};
    tbl[25] = '{1'b1, 8'h21, 1'b1, 1'b0, 7'h0F, 5'b11010};
    tbl[26] = '{1'b0, 8'h80, 1'b1, 1'b0, 7'h00, 5'b11010};
    tbl[27] = '{1'b0, 8'h10, 1'b1, 1'b0, 7'h4F, 5'b11010};
    tbl[28] = '{1'b0, 8'h06, 1'b1, 1'b0, 7'h4F, 5'b11011};
    tbl[29] = '{1'b0, 8'h90, 1'b0, 1'b1, 7'h4F, 5'b11011};
    tbl[30] = '{1'b0, 8'h1C, 1'b1, 1'b0, 7'h4F, 5'b11011};
    tbl[31] = '{1'b0, 8'h40, 1'b1, 1'b0, 7'h4F, 5'b11011};
    tbl[32] = '{1'b0, 8'h20, 1'b1, 1'b1, 7'h4F, 5'b11001};
    tbl[33] = '{1'b0, 8'h38, 1'b1, 1'b0, 7'h4F, 5'b11011};
    tbl[34] = '{1'b0, 8'h0D, 1'b1, 1'b0, 7'h4F, 5'b10111};
    tbl[35] = '{1'b1, 8'h5A, 1'b1, 1'b0, 7'h00, 5'b10111};

    // Reset and power-on sweep
    repeat (2) step();
    do_reset();
    check("ac_after_sweep", 32'(ac), 32'h00);
    check_mirror("mirror_sweep");

    // Table-driven vectors
    prev_ac = 7'h00;
    for (int i = 0; i < NV; i++) begin
      xfer(tbl[i].rs, 1'b0, tbl[i].d, v, e, code);
      check($sformatf("valid[%0d]", i), 32'(v), 32'(tbl[i].v));
      check($sformatf("err[%0d]", i), 32'(e), 32'(tbl[i].e));
      if (tbl[i].v) check($sformatf("code[%0d]", i), 32'(code), 32'({tbl[i].rs, tbl[i].d}));
      check($sformatf("ac[%0d]", i), 32'(ac), 32'(tbl[i].ac));
      check($sformatf("flags[%0d]", i),
            32'({display_on, cursor_on, blink_on, two_line, incr}), 32'(tbl[i].fl));
      if (tbl[i].rs) exp_mem[{prev_ac[6], prev_ac[3:0]}] = tbl[i].d;
      prev_ac = tbl[i].ac;
    end
    check("cell26", 32'(exp_mem[26]), 32'h2B);
    check_mirror("mirror_table");

    // EN fall to cmd_valid latency, and busy window length
    strobe(1'b0, 1'b0, 8'h06);
    n = 0;
    while (!cmd_valid && n < 20) begin step(); n++; end
    check("fall_latency", 32'(n), 32'd4);
    check("busy_with_valid", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    check("busy_len", 32'(n), 32'd4);

`ifdef LCD_RESPONDER_READ_EN
    xfer(1'b0, 1'b0, 8'hCB, v, e, code);
    xfer(1'b1, 1'b0, 8'h77, v, e, code);
    exp_mem[27] = 8'h77;
    xfer(1'b0, 1'b0, 8'hCB, v, e, code);
    check("rd_setup_ac", 32'(ac), 32'h4B);
    strobe(1'b0, 1'b1, 8'h00);
    check("rd_bf_oe", 32'(db_oe), 32'd1);
    check("rd_bf_data", 32'(db_out), 32'h4B);
    monitor(12, v, e, code);
    wait_idle();
    check("rd_bf_valid", 32'({v, e}), 32'b10);
    check("rd_bf_oe_off", 32'(db_oe), 32'd0);
    rs = 1'b1; rw = 1'b1; en = 1'b1;
    repeat (6) step();
    check("rd_dd_oe", 32'(db_oe), 32'd1);
    check("rd_dd_data", 32'(db_out), 32'h77);
    en = 1'b0;
    monitor(12, v, e, code);
    wait_idle();
    check("rd_dd_ac", 32'(ac), 32'h4C);
    check("rd_dd_oe_off", 32'(db_oe), 32'd0);
`else
    xfer(1'b0, 1'b1, 8'h00, v, e, code);
    check("rw_drop", 32'({v, e}), 32'b01);
    check("rw_drop_ac", 32'(ac), 32'h00);
    check("rw_drop_bus", 32'({db_oe, db_out}), 32'd0);
`endif
    rw = 1'b0;

    // Clear mid-session, with a strobe that lands during the sweep
    xfer(1'b0, 1'b0, 8'h04, v, e, code);
    check("pre_clear_incr", 32'(incr), 32'd0);
    strobe(1'b0, 1'b0, 8'h01);
    n = 0;
    while (!cmd_valid && n < 20) begin step(); n++; end
    check("clear_valid", 32'(cmd_valid), 32'd1);
    repeat (2) step();
    strobe(1'b1, 1'b0, 8'h55);
    monitor(12, v, e, code);
    check("drop_err", 32'({v, e}), 32'b01);
    wait_idle();
    check("clear_ac", 32'(ac), 32'h00);
    check("clear_incr", 32'(incr), 32'd1);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    check_mirror("mirror_clear");

    // Reset while a clear sweep is running
    xfer(1'b0, 1'b0, 8'h0F, v, e, code);
    check("pre_rst_display", 32'({display_on, cursor_on, blink_on}), 32'b111);
    strobe(1'b0, 1'b0, 8'h01);
    monitor(8, v, e, code);
    check("clear2_valid", 32'(v), 32'd1);
    repeat (3) step();
    do_reset();
    check_mirror("mirror_rst_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

HD44780-compatible display-side responder: the receiving end of the 8-bit parallel LCD bus driven by the team's LCD command/character writer. It samples EN/RS/RW/DB, decodes instructions and character writes on each EN falling edge, maintains a 2×16 DDRAM mirror, address counter (AC) and display flags, and exposes them to the simulation bench and to on-board debug logic. Sits directly on the LCD pins, in parallel with or in place of the physical module.

## Interface

- `EXEC_CYCLES`, 4: busy duration after every accepted instruction or data write.
- `SYNC_STAGES`, 2: synchronizer depth on `en`, `rs`, `rw`, `db` (≥2).
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: bus enable strobe; transfer latched on falling edge.
- `rs` in 1: 0 = instruction, 1 = data.
- `rw` in 1: 0 = write, 1 = read.
- `db` in 8: bus data from writer.
- `rd_addr` in 5: mirror read address; bit 4 = line, [3:0] = column.
- `rd_char` out 8: mirror contents at `rd_addr`, registered.
- `ac` out 7: current DDRAM address counter.
- `display_on`, `cursor_on`, `blink_on`, `two_line`, `incr` out 1 each: display control, function-set and entry-mode flags.
- `busy` out 1: busy flag.
- `cmd_valid` out 1: one-cycle pulse per accepted transfer; `cmd_code` out 9 = {rs, db}.
- `err` out 1: one-cycle pulse on dropped or illegal transfer.
- `db_out` out 8, `db_oe` out 1: read-back path (see Configuration).

## Operation

- States: SWEEP (fill mirror with 0x20, one cell/cycle, 32 cycles), IDLE, EXEC (countdown EXEC_CYCLES), back to IDLE.
- Falling edge = synchronized `en` 1 then 0 on consecutive cycles; `rs`/`rw`/`db` taken from the stage aligned with the last high sample.
- Edge while `busy`=1 (SWEEP or EXEC): transfer dropped, `err` pulses, no state change.
- Instruction decode (rs=0, rw=0), highest set bit wins:
  - 0x01 clear: AC=0, incr=1, enter SWEEP then EXEC.
  - 0x02/0x03 home: AC=0.
  - 0x04–0x07 entry: incr=db[1]; db[0] (display shift) ignored.
  - 0x08–0x0F: display_on=db[2], cursor_on=db[1], blink_on=db[0].
  - 0x10–0x1F: if db[3]=0 move AC (db[2]=1 right, 0 left, wrap rules below); db[3]=1 display shift: no effect besides `cmd_valid`.
  - 0x20–0x3F: two_line=db[3]; db[4]=0 (4-bit mode) flags `err`, still updates two_line.
  - 0x40–0x7F (CGRAM): ignored, `cmd_valid` still pulses.
  - 0x80–0xFF: AC=db[6:0] if db[5:4]=00; else `err`, AC unchanged.
- Data write (rs=1, rw=0): cell[{AC[6], AC[3:0]}] ← db, then AC steps per `incr`.
- AC stepping: incr 0x0F→0x40, 0x4F→0x00; decr 0x00→0x4F, 0x40→0x0F; otherwise ±1 within a line.
- Accepted non-dropped transfer: `cmd_valid`=1, `cmd_code`={rs,db}, then EXEC.
- `rst` mid-operation: all registers to reset values, SWEEP restarts from cell 0.

## Timing

- Reset values: ac=0, incr=1, display_on=cursor_on=blink_on=two_line=0, busy=1, cmd_valid=err=0, db_oe=0, db_out=0, rd_char=0x00 until first read after SWEEP.
- SWEEP after reset/clear: 32 cycles; busy stays high through following EXEC (total 32+EXEC_CYCLES).
- EN pin fall → edge detected SYNC_STAGES+1 clk edges later → AC/flags/mirror/`cmd_valid` update on the next edge.
- `busy` rises same edge as `cmd_valid`, falls exactly EXEC_CYCLES cycles later.
- `rd_char` latency 1 cycle from `rd_addr`; a same-cycle write to the read cell returns the old value.
- EN high must be held ≥ SYNC_STAGES+1 cycles to be seen; shorter pulses may be lost, not required to flag.

## Configuration

- `LCD_RESPONDER_READ_EN` defined: rw=1 transfers honoured; on EN rising edge (synchronized) with rw=1, `db_oe`=1 and `db_out`={busy, ac} (rs=0) or mirror[AC] (rs=1); on falling edge `db_oe`=0 and rs=1 reads step AC. Read of busy flag is accepted even while busy.
- Undefined: rw=1 edges dropped with `err` pulse; `db_out`=0, `db_oe`=0 permanently.

## Test plan

- Assert `rst` 1 cycle, release → busy high 36 cycles (EXEC_CYCLES=4), then all 32 `rd_char` = 0x20, ac=0.
- Instructions 0x38, 0x0E, 0x06 → two_line=1, display_on=1, cursor_on=1, blink_on=0, incr=1, three `cmd_valid` pulses with cmd_code 0x038/0x00E/0x006.
- 0x02 then data 0x4C,0x4F,0x41,0x44 → cells 0–3 = "LOAD", ac=0x04.
- 0xC0, ten 0x14, data 0x2B → line 2 column 10 = 0x2B, ac=0x4B; 0x8F then data 0x58 → cell 15 = 0x58, ac=0x40.
- Second EN strobe issued 2 cycles after an accepted write → `err` pulse, mirror and ac unchanged; 0x01 mid-session → all cells 0x20, ac=0; `rst` during SWEEP restarts sweep.
- With `LCD_RESPONDER_READ_EN`: rw=1, rs=0 while idle at ac=0x4B → db_out=0x4B, db_oe=1 during EN high; rs=1 → db_out=mirror[0x4B], ac=0x4C after fall.
